// File: rtl/hex_scan_ctrl_pkg.sv
// Shared definitions for the hex scan display controller.
// Holds the active-low segment patterns, the scan state encoding and a
// width helper used to size index and counter registers.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } disp_state_e;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit0=a .. bit6=g; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_MAP = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Host/display bundle for hex_scan_ctrl.
//   master: host side, drives enable, shadow writes, blank mask and update;
//           observes update_pending, frame_start and the display pins.
//   slave : controller side, the reverse directions.
interface hex_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  import hex_disp_pkg::*;

  localparam int AW = idx_w(N_DIGITS);

  logic                en;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [3:0]          wr_data;
  logic [N_DIGITS-1:0] blank_mask;
  logic                update;
  logic                update_pending;
  logic                frame_start;
  logic [N_DIGITS-1:0] an;
  logic [6:0]          seg;

  modport master (
    output en, wr_en, wr_addr, wr_data, blank_mask, update,
    input  update_pending, frame_start, an, seg
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data, blank_mask, update,
    output update_pending, frame_start, an, seg
  );

endinterface

// File: rtl/hex_scan_ctrl_seg_lut.sv
// Hex nibble to active-low seven-segment pattern (purely combinational).
//   i_nibble : 4-bit hex value
//   o_seg    : 7-bit pattern, bit0=a .. bit6=g, 0 = segment lit
module hex_seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_MAP[i_nibble];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus_if : slave side of hex_scan_ctrl_if (enable, shadow writes, blank
//            mask, commit request, update_pending, frame_start, an, seg)
// Each digit slot is BLANK_CYCLES dark clocks followed by DWELL_CYCLES lit
// clocks. Shadow nibbles are copied to the active set at a frame boundary
// once a commit has been requested.
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  hex_scan_ctrl_if.slave   bus_if
);

  localparam int AW   = idx_w(N_DIGITS);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = idx_w(CMAX);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [AW-1:0] IDX_LAST   = AW'(N_DIGITS - 1);

  disp_state_e                r_state, w_state_d;
  disp_state_e                w_slot_first_state;
  logic [AW-1:0]              r_idx, w_idx_d;
  logic [CW-1:0]              r_cnt, w_cnt_d;
  logic [N_DIGITS-1:0][3:0]   r_shadow, r_active;
  logic                       r_pending;
  logic                       r_frame_start;
  logic [N_DIGITS-1:0]        r_an;
  logic [6:0]                 r_seg;
  logic                       w_boundary;
  logic                       w_lit;
  logic [6:0]                 w_lut_seg;

  // First phase of every slot: BLANK, or SHOW when there is no gap.
  assign w_slot_first_state = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_cnt_d    = r_cnt;
    w_boundary = 1'b0;
    if (!bus_if.en) begin
      w_state_d = OFF;
      w_idx_d   = '0;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        OFF: begin
          w_boundary = 1'b1;
          w_state_d  = w_slot_first_state;
          w_idx_d    = '0;
          w_cnt_d    = '0;
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_d = SHOW;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_d = w_slot_first_state;
            w_cnt_d   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_d    = '0;
              w_boundary = 1'b1;
            end else begin
              w_idx_d = r_idx + 1'b1;
            end
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: w_state_d = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Commit copies the shadow as it was before any write on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus_if.wr_en && (int'(bus_if.wr_addr) < N_DIGITS)) begin
        r_shadow[bus_if.wr_addr] <= bus_if.wr_data;
      end
      if (w_boundary) begin
        if (r_pending || bus_if.update) begin
          r_active <= r_shadow;
        end
        r_pending <= 1'b0;
      end else if (bus_if.update) begin
        r_pending <= 1'b1;
      end
    end
  end

  hex_seg_lut u_seg_lut (
    .i_nibble (r_active[r_idx]),
    .o_seg    (w_lut_seg)
  );

  // Gating with en makes the pins go dark on the edge that leaves the scan.
  assign w_lit = bus_if.en && (r_state == SHOW) && !bus_if.blank_mask[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_lit ? ~(N_DIGITS'(1) << r_idx) : '1;
      r_seg         <= w_lit ? w_lut_seg : SEG_BLANK;
      r_frame_start <= bus_if.en && (r_state == w_slot_first_state) &&
                       (r_idx == '0) && (r_cnt == '0);
    end
  end

  assign bus_if.an             = r_an;
  assign bus_if.seg            = r_seg;
  assign bus_if.frame_start    = r_frame_start;
  assign bus_if.update_pending = r_pending;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (4 digits, dwell 4, blank 2).
// The reference model tracks the position inside the frame as plain
// arithmetic on elapsed run cycles and keeps shadow/active nibble arrays.
module tb_hex_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BK    = 2;
  localparam int SLOT  = BK + DW;
  localparam int FRAME = ND * SLOT;

  logic clk;
  logic rst_n;

  hex_scan_ctrl_if #(.N_DIGITS(ND)) bus ();

  hex_scan_ctrl #(
    .N_DIGITS     (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BK)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  bit         m_run;
  int         m_t;
  logic [3:0] m_act [ND];
  logic [3:0] m_sh  [ND];
  bit         m_pend;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  bit         e_fs;

  task automatic model_reset();
    m_run  = 0;
    m_t    = 0;
    m_pend = 0;
    for (int i = 0; i < ND; i++) begin
      m_act[i] = 4'h0;
      m_sh[i]  = 4'h0;
    end
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_fs  = 0;
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // then settle to a sampling point 1 unit after the edge.
  task automatic tick();
    int pos, d, ph;
    bit boundary;
    @(posedge clk);
    cyc++;
    pos = m_t % FRAME;
    d   = pos / SLOT;
    ph  = pos % SLOT;
    if (m_run && bus.en && ph >= BK && !bus.blank_mask[d]) begin
      e_an  = ~(4'b0001 << d);
      e_seg = seg_tbl[m_act[d]];
    end else begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
    end
    e_fs = m_run && bus.en && (pos == 0);
    boundary = bus.en && (!m_run || pos == FRAME - 1);
    if (boundary) begin
      if (m_pend || bus.update) begin
        for (int i = 0; i < ND; i++) m_act[i] = m_sh[i];
      end
      m_pend = 0;
    end else if (bus.update) begin
      m_pend = 1;
    end
    if (bus.wr_en) m_sh[bus.wr_addr] = bus.wr_data;
    if (!bus.en) begin
      m_run = 0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
    end else begin
      m_t = m_t + 1;
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = 4'h0;
    bus.update  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.blank_mask = '0;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
      bad++;
      $display("FAIL reset_pins: an=%h seg=%h, expected an=F seg=7F", bus.an, bus.seg);
    end
    total++;
    if (bus.update_pending !== 1'b0 || bus.frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: pend=%b fs=%b, expected 0 0",
               bus.update_pending, bus.frame_start);
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs) begin
        bad++;
        $display("FAIL reset_idle: an=%h seg=%h fs=%b, expected an=%h seg=%h fs=%b",
                 bus.an, bus.seg, bus.frame_start, e_an, e_seg, e_fs);
      end
    end
  endtask

  task automatic test_scan_default();
    int last = -1;
    int pulses = 0;
    bus.en = 1'b1;
    repeat (2 * FRAME + 3) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs ||
          bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL scan_default c=%0d: an=%h seg=%h fs=%b pend=%b, expected %h %h %b %b",
                 cyc, bus.an, bus.seg, bus.frame_start, bus.update_pending,
                 e_an, e_seg, e_fs, m_pend);
      end
      if (bus.frame_start === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          total++;
          if (cyc - last != FRAME) begin
            bad++;
            $display("FAIL frame_period: got=%0d expected=%0d", cyc - last, FRAME);
          end
        end
        last = cyc;
      end
    end
    total++;
    if (pulses < 2) begin
      bad++;
      $display("FAIL frame_pulses: got=%0d expected>=2", pulses);
    end
  endtask

  task automatic test_commit();
    logic [3:0] vals [ND];
    vals[0] = 4'h1; vals[1] = 4'h8; vals[2] = 4'hA; vals[3] = 4'hF;
    for (int i = 0; i < ND; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = vals[i];
      tick();
      drive_idle();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL commit_write: an=%h seg=%h pend=%b, expected %h %h %b",
                 bus.an, bus.seg, bus.update_pending, e_an, e_seg, m_pend);
      end
    end
    while (m_t % FRAME != 10) tick();
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs ||
          bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL commit c=%0d: an=%h seg=%h fs=%b pend=%b, expected %h %h %b %b",
                 cyc, bus.an, bus.seg, bus.frame_start, bus.update_pending,
                 e_an, e_seg, e_fs, m_pend);
      end
    end
  endtask

  task automatic test_write_no_update();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd2;
    bus.wr_data = 4'h5;
    tick();
    drive_idle();
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL write_hold c=%0d: an=%h seg=%h pend=%b, expected %h %h %b",
                 cyc, bus.an, bus.seg, bus.update_pending, e_an, e_seg, m_pend);
      end
    end
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL write_commit c=%0d: an=%h seg=%h pend=%b, expected %h %h %b",
                 cyc, bus.an, bus.seg, bus.update_pending, e_an, e_seg, m_pend);
      end
    end
  endtask

  task automatic test_blank_mask();
    bus.blank_mask = 4'b0010;
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs) begin
        bad++;
        $display("FAIL blank_mask c=%0d: an=%h seg=%h fs=%b, expected %h %h %b",
                 cyc, bus.an, bus.seg, bus.frame_start, e_an, e_seg, e_fs);
      end
    end
    bus.blank_mask = '0;
  endtask

  task automatic test_boundary_update();
    while (m_t % FRAME != FRAME - 1) tick();
    for (int i = 0; i < ND; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = 4'($urandom_range(15));
      tick();
    end
    drive_idle();
    while (m_t % FRAME != FRAME - 1) tick();
    bus.update  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'($urandom_range(3));
    bus.wr_data = 4'($urandom_range(15));
    tick();
    drive_idle();
    repeat (2 * FRAME) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs ||
          bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL boundary_update c=%0d: an=%h seg=%h fs=%b pend=%b, expected %h %h %b %b",
                 cyc, bus.an, bus.seg, bus.frame_start, bus.update_pending,
                 e_an, e_seg, e_fs, m_pend);
      end
    end
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < ND; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = 4'($urandom_range(15));
      tick();
    end
    drive_idle();
    while (m_t % FRAME != 2 * SLOT + 2) tick();
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    bus.en = 1'b0;
    tick();
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
      bad++;
      $display("FAIL en_drop_dark: an=%h seg=%h, expected an=F seg=7F", bus.an, bus.seg);
    end
    total++;
    if (bus.update_pending !== 1'b1) begin
      bad++;
      $display("FAIL en_drop_pend: pend=%b expected 1", bus.update_pending);
    end
    repeat (5) tick();
    bus.en = 1'b1;
    repeat (FRAME + 4) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs ||
          bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL en_reentry c=%0d: an=%h seg=%h fs=%b pend=%b, expected %h %h %b %b",
                 cyc, bus.an, bus.seg, bus.frame_start, bus.update_pending,
                 e_an, e_seg, e_fs, m_pend);
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      bus.wr_en   = ($urandom_range(2) == 0);
      bus.wr_addr = 2'($urandom_range(3));
      bus.wr_data = 4'($urandom_range(15));
      bus.update  = ($urandom_range(15) == 0);
      if ($urandom_range(49) == 0) bus.blank_mask = 4'($urandom_range(15));
      if ($urandom_range(199) == 0) bus.en = ~bus.en;
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs ||
          bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL random c=%0d: an=%h seg=%h fs=%b pend=%b, expected %h %h %b %b",
                 cyc, bus.an, bus.seg, bus.frame_start, bus.update_pending,
                 e_an, e_seg, e_fs, m_pend);
      end
    end
    drive_idle();
    bus.blank_mask = '0;
    bus.en = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < ND; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = 4'($urandom_range(1, 15));
      tick();
    end
    drive_idle();
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    repeat (FRAME) tick();
    while (m_t % FRAME != SLOT + BK + 1) tick();
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.update_pending !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: an=%h seg=%h pend=%b, expected an=F seg=7F pend=0",
               bus.an, bus.seg, bus.update_pending);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (FRAME + 4) begin
      tick();
      total++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs ||
          bus.update_pending !== m_pend) begin
        bad++;
        $display("FAIL post_reset c=%0d: an=%h seg=%h fs=%b pend=%b, expected %h %h %b %b",
                 cyc, bus.an, bus.seg, bus.frame_start, bus.update_pending,
                 e_an, e_seg, e_fs, m_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_default();
    test_commit();
    test_write_no_update();
    test_blank_mask();
    test_boundary_update();
    test_en_drop();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one segment bus.
- Holds one hex nibble per digit in a double-buffered register file.
- Sequences the digits with a per-digit dwell and an anti-ghosting blank gap.
- Drives active-low anodes and active-low segments through an internal hex-to-segment lookup.
- Sits between the host logic (register writes) and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- DWELL_CYCLES, 50000, clocks each digit is lit (>=1).
- BLANK_CYCLES, 500, clocks all anodes are off before each digit (0 = no gap).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  display enable; 0 forces the display dark.
- wr_en  in  1  write strobe into the shadow register.
- wr_addr  in  clog2(N_DIGITS) (min 1)  digit index to write.
- wr_data  in  4  hex nibble.
- blank_mask  in  N_DIGITS  bit i=1 keeps digit i dark; sampled live, not buffered.
- update  in  1  request to commit shadow to active at the next frame boundary.
- update_pending  out  1  commit requested but not yet done.
- frame_start  out  1  one-cycle pulse when digit 0 slot begins.
- an  out  N_DIGITS  anode select, active-low, one-hot-low when lit.
- seg  out  7  segments, active-low; bit0=a .. bit6=g.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - shadow and active nibbles = 0; update_pending = 0; frame_start = 0.
  - an = all 1; seg = 7'h7F.
  - state = OFF; digit index = 0; slot counter = 0.
- Segment map (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Dark = 7F.
- State machine:
  - OFF: en=0. an all 1, seg 7F, counters held at 0. en=1 -> BLANK with digit 0 (frame boundary), or SHOW with digit 0 if BLANK_CYCLES=0.
  - BLANK: an all 1, seg 7F for BLANK_CYCLES clocks, then -> SHOW.
  - SHOW: an[idx]=0, seg=map(active[idx]) for DWELL_CYCLES clocks, then advance idx. Next state is BLANK, or SHOW if BLANK_CYCLES=0.
- Digit index wrap: idx wraps N_DIGITS-1 -> 0. Each wrap, and each OFF->run entry, is a frame boundary.
- blank_mask[idx]=1 during SHOW: an stays all 1, seg 7F. Slot timing is unchanged.
- Outputs an, seg and frame_start are registered: they reflect the state and counter one clock later.
- Slot = BLANK_CYCLES + DWELL_CYCLES clocks; frame = N_DIGITS x slot.
- Shadow writes:
  - wr_en=1 writes shadow[wr_addr] at the clock edge.
  - wr_addr >= N_DIGITS is ignored.
  - Writes never alter the active nibbles directly.
- Commit:
  - update=1 sets update_pending.
  - At a frame boundary with update_pending=1: active <= shadow (contents before any same-cycle write), then update_pending clears.
  - update on the boundary cycle itself: that boundary commits and pending stays 0.
  - A write coincident with the boundary lands in shadow only.
- frame_start pulses on the first registered output cycle of each frame.
- en falling mid-slot:
  - Next clock -> OFF, idx=0, counters cleared.
  - update_pending and both register files are retained.
- Asynchronous reset mid-frame: immediate return to reset values, independent of clk.

Decomposition:
- Shared package hex_disp_pkg holds:
  - the segment constants (SEG_BLANK = 7'h7F and the 16-entry map);
  - the state enum {OFF, BLANK, SHOW}.
- One combinational sub-module, hex_seg_lut: 4-bit nibble -> 7-bit active-low pattern.
- The counters and FSM stay in the top level.

Test Plan (N_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2):
- Reset then en=1 with no writes -> slot order for digits 0..3: 2 cycles an=F, seg=7F, then 4 cycles an=E/D/B/7 with seg=40. frame_start pulses every 24 clocks.
- Write shadow {3,2,1,0} = {F,A,8,1}, then update=1 mid-frame -> current frame unchanged (seg=40). Next frame shows seg 79, 00, 08, 0E on digits 0..3; update_pending clears at the boundary.
- wr_en with wr_addr=2, wr_data=5 and no update -> displayed values never change. Later update -> digit 2 shows 12 from the next frame.
- blank_mask=4'b0010 -> digit 1 slot has an=F, seg=7F for 4 cycles; the other digits and timing are unaffected.
- en dropped during digit 2 SHOW with update_pending=1 -> one clock later an=F, seg=7F. Re-enable -> commit at entry, digit 0 slot starts, frame_start pulses.
- rst_n asserted mid-SHOW -> an=F, seg=7F, update_pending=0 immediately without a clock edge. Active nibbles read 0 after release.
